// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep stage.
//   tt_state_e : sweep FSM states (TT_IDLE, TT_DRIVE, TT_DONE)
//   TT_ROWS    : number of truth-table rows for a 3-input circuit
//   TT_ROW_W   : width of the row index / stimulus vector
//   tt_bit()   : row index -> bit position in the captured table (row 000 is the MSB)
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_DRIVE = 2'd1,
    TT_DONE  = 2'd2
  } tt_state_e;

  localparam int TT_ROWS  = 8;
  localparam int TT_ROW_W = 3;

  function automatic logic [TT_ROW_W-1:0] tt_bit(input logic [TT_ROW_W-1:0] row);
    return TT_ROW_W'(TT_ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/truth_table_sweep_if.sv
// Control/report bundle between a sweep requester (master) and the
// truth_table_sweep stage (slave).
//   start  : master -> slave, level request; sampled only while the stage is idle,
//            ignored (not queued) otherwise.
//   busy   : slave -> master, high from the first drive cycle through the done cycle.
//   done   : slave -> master, one-cycle pulse when the sweep completes.
//   result : slave -> master, captured truth table (row 000 in bit 7).
//   pass   : slave -> master, result == expected; valid from done until the next
//            accepted start.
// There is no ready signal: a start seen while idle is accepted on that edge, and
// busy tells the master when a new request would be honoured.
interface truth_table_sweep_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       pass;

  modport master (output start, input busy, input done, input result, input pass);
  modport slave  (input start, output busy, output done, output result, output pass);
endinterface

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output (two cycles of latency)
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/truth_table_sweep.sv
// Stimulus and capture stage for a 3-input combinational circuit. On start it
// drives {in1,in2,in3} through rows 000..111, holds each row for a settle time,
// samples the circuit output at the last edge of the row, and reports the
// captured 8-bit truth table plus a compare against EXPECTED.
//
// Parameters:
//   EXPECTED : expected truth table, bit [7-r] is the output for row r
//   SETTLE   : cycles per row before sampling (1..255; 1..254 with the synchronizer)
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : start / busy / done / result / pass
//   dut_out          : output of the circuit under test
//   in1, in2, in3    : registered stimulus to the circuit under test
//   state            : current FSM state, for observation
// Build option:
//   TT_SWEEP_SYNC_EN : pass dut_out through a 2-flop synchronizer and extend each
//                      row by two cycles so the sampled value belongs to the row.
module truth_table_sweep
  import tt_sweep_pkg::*;
#(
  parameter logic [7:0] EXPECTED = 8'h47,
  parameter int         SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  truth_table_sweep_if.slave  bus,
  input  logic                dut_out,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output tt_state_e           state
);

  logic sample;

`ifdef TT_SWEEP_SYNC_EN
  localparam logic [7:0] SAMPLE_AT = 8'(SETTLE + 1);

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (sample)
  );
`else
  localparam logic [7:0] SAMPLE_AT = 8'(SETTLE - 1);

  assign sample = dut_out;
`endif

  tt_state_e             state_q, state_d;
  logic [TT_ROW_W-1:0]   row_q, row_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            result_q, result_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TT_IDLE;
      row_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    pass_d   = pass_q;

    case (state_q)
      TT_IDLE: begin
        row_d = '0;
        cnt_d = '0;
        if (bus.start) begin
          state_d  = TT_DRIVE;
          result_d = '0;
          pass_d   = 1'b0;
        end
      end
      TT_DRIVE: begin
        if (cnt_q == SAMPLE_AT) begin
          cnt_d                  = '0;
          result_d[tt_bit(row_q)] = sample;
          if (row_q == TT_ROW_W'(TT_ROWS - 1)) begin
            // Stimulus returns to 000 for the done cycle; the compare uses the
            // table including the bit captured on this edge.
            state_d = TT_DONE;
            row_d   = '0;
            pass_d  = (result_d == EXPECTED);
          end else begin
            row_d = row_q + TT_ROW_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TT_DONE: begin
        state_d = TT_IDLE;
      end
      default: begin
        state_d = TT_IDLE;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    busy_d = (state_d != TT_IDLE);
    done_d = (state_d == TT_DONE);
  end

  assign {in1, in2, in3} = row_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.pass        = pass_q;
  assign state           = state_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep: two instances (main SETTLE and SETTLE=1)
// driving a behavioural 0x47 circuit, with an optional row-110 fault on the main one.
module tb_truth_table_sweep;
  import tt_sweep_pkg::*;

`ifdef TT_SWEEP_SYNC_EN
  localparam int SETTLE_A = 2;
  localparam int P_A      = 4;
  localparam int P_B      = 3;
`else
  localparam int SETTLE_A = 4;
  localparam int P_A      = 4;
  localparam int P_B      = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic fault_en;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and circuit model ----------------
  truth_table_sweep_if if_a ();
  truth_table_sweep_if if_b ();

  logic      a_in1, a_in2, a_in3, a_out;
  logic      b_in1, b_in2, b_in3, b_out;
  tt_state_e a_state, b_state;

  // 0x47 circuit: high for rows 001, 101, 110, 111; optional fault inverts row 110.
  function automatic logic circuit(input logic [2:0] r, input logic flt);
    logic f;
    f = (r[2] & (r[1] | r[0])) | (~r[2] & ~r[1] & r[0]);
    return f ^ (flt & (r == 3'b110));
  endfunction

  assign a_out = circuit({a_in1, a_in2, a_in3}, fault_en);
  assign b_out = circuit({b_in1, b_in2, b_in3}, 1'b0);

  truth_table_sweep #(.EXPECTED(8'h47), .SETTLE(SETTLE_A)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if_a.slave),
    .dut_out (a_out),
    .in1     (a_in1),
    .in2     (a_in2),
    .in3     (a_in3),
    .state   (a_state)
  );

  truth_table_sweep #(.EXPECTED(8'h47), .SETTLE(1)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if_b.slave),
    .dut_out (b_out),
    .in1     (b_in1),
    .in2     (b_in2),
    .in3     (b_in3),
    .state   (b_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic set_start(input int w, input logic v);
    if (w == 0) if_a.start = v;
    else        if_b.start = v;
  endtask

  function automatic logic [2:0] rd_in(input int w);
    return (w == 0) ? {a_in1, a_in2, a_in3} : {b_in1, b_in2, b_in3};
  endfunction
  function automatic logic rd_busy(input int w);
    return (w == 0) ? if_a.busy : if_b.busy;
  endfunction
  function automatic logic rd_done(input int w);
    return (w == 0) ? if_a.done : if_b.done;
  endfunction
  function automatic logic [7:0] rd_result(input int w);
    return (w == 0) ? if_a.result : if_b.result;
  endfunction
  function automatic logic rd_pass(input int w);
    return (w == 0) ? if_a.pass : if_b.pass;
  endfunction

  // One pulsed-start sweep; checks stimulus every cycle, done cycle, result, pass.
  // mid_start > 0 pulses start again in that cycle to show it is ignored.
  task automatic run_sweep(input int w, input int p, input logic [7:0] exp_res,
                           input logic exp_pass, input int mid_start, input string tag);
    int done_cyc;
    logic [2:0] e;
    exp_q.delete();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < p; k++) exp_q.push_back(3'(r));
    @(posedge clk); #1 set_start(w, 1'b1);
    @(posedge clk); #1 set_start(w, 1'b0);   // now in cycle 1
    check({tag, "_busy_c1"}, 32'(rd_busy(w)), 32'd1);
    check({tag, "_result_clr"}, 32'(rd_result(w)), 32'h0);
    done_cyc = 0;
    for (int n = 1; n <= 8 * p + 10; n++) begin
      set_start(w, n == mid_start);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_row"}, 32'(rd_in(w)), 32'(e));
      end
      if (rd_done(w)) begin
        done_cyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    set_start(w, 1'b0);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(8 * p + 1));
    check({tag, "_busy_done"}, 32'(rd_busy(w)), 32'd1);
    check({tag, "_result"}, 32'(rd_result(w)), 32'(exp_res));
    check({tag, "_pass"}, 32'(rd_pass(w)), 32'(exp_pass));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(rd_done(w)), 32'd0);
    check({tag, "_idle_busy"}, 32'(rd_busy(w)), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_no_requeue"}, 32'(rd_busy(w)), 32'd0);
    check({tag, "_result_hold"}, 32'(rd_result(w)), 32'(exp_res));
    check({tag, "_pass_hold"}, 32'(rd_pass(w)), 32'(exp_pass));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int period;
    int ndone;
    int last_done;
    int waited;

    rst_n      = 1'b0;
    fault_en   = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in", 32'({a_in1, a_in2, a_in3}), 32'd0);
    check("rst_busy", 32'(if_a.busy), 32'd0);
    check("rst_done", 32'(if_a.done), 32'd0);
    check("rst_pass", 32'(if_a.pass), 32'd0);
    check("rst_result", 32'(if_a.result), 32'h0);
    check("rst_state", 32'(a_state), 32'(TT_IDLE));
    @(negedge clk) rst_n = 1'b1;

    // Golden circuit, with a start pulse in the middle that must be ignored
    run_sweep(0, P_A, 8'h47, 1'b1, 10, "golden");

    // Faulty circuit (row 110 inverted)
    fault_en = 1'b1;
    run_sweep(0, P_A, 8'h45, 1'b0, 0, "faulty");
    fault_en = 1'b0;

    // Start held high: one done per 8*P+2 cycles, result/pass cleared on restart
    period    = 8 * P_A + 2;
    ndone     = 0;
    last_done = -10;
    @(posedge clk); #1 if_a.start = 1'b1;
    @(posedge clk); #1;                       // cycle 1 of first sweep
    check("held_result_clr", 32'(if_a.result), 32'h0);
    for (int n = 1; n <= 3 * period; n++) begin
      if (if_a.done) begin
        check("held_done_cycle", 32'(n), 32'(8 * P_A + 1 + ndone * period));
        check("held_result", 32'(if_a.result), 32'h47);
        ndone++;
        last_done = n;
      end
      if (n == last_done + 1) begin
        check("held_idle_busy", 32'(if_a.busy), 32'd0);
        check("held_idle_pass", 32'(if_a.pass), 32'd1);
      end
      if (n == last_done + 2) begin
        check("held_restart_busy", 32'(if_a.busy), 32'd1);
        check("held_restart_result", 32'(if_a.result), 32'h0);
        check("held_restart_pass", 32'(if_a.pass), 32'd0);
      end
      @(posedge clk); #1;
    end
    if_a.start = 1'b0;
    check("held_done_count", 32'(ndone), 32'd3);
    waited = 0;
    while (if_a.busy && waited < 2 * period) begin
      @(posedge clk); #1;
      waited++;
    end
    check("held_drain", 32'(if_a.busy), 32'd0);

    // Reset in the middle of row 3
    @(posedge clk); #1 if_a.start = 1'b1;
    @(posedge clk); #1 if_a.start = 1'b0;     // cycle 1
    repeat (3 * P_A + 1) @(posedge clk);
    #1;                                        // cycle 3P+2, inside row 3
    check("mid_row3", 32'({a_in1, a_in2, a_in3}), 32'd3);
    check("mid_partial", 32'(if_a.result), 32'h40);
    rst_n = 1'b0;
    #2;
    check("mid_rst_in", 32'({a_in1, a_in2, a_in3}), 32'd0);
    check("mid_rst_busy", 32'(if_a.busy), 32'd0);
    check("mid_rst_result", 32'(if_a.result), 32'h0);
    check("mid_rst_pass", 32'(if_a.pass), 32'd0);
    check("mid_rst_state", 32'(a_state), 32'(TT_IDLE));
    @(negedge clk) rst_n = 1'b1;
    run_sweep(0, P_A, 8'h47, 1'b1, 0, "after_rst");

    // SETTLE = 1 instance
    run_sweep(1, P_B, 8'h47, 1'b1, 0, "settle1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
